// File: rtl/calc2_engine_if.sv
// Requester-side bus of calc2_engine: per-port command/tag/operand inputs,
// ready backpressure, and the response channel (resp code, echoed tag, result).
// Fields for port p sit at [W*p +: W] of each flattened vector.
//   master : requester side (drives commands, receives ready and responses)
//   slave  : engine side    (receives commands, drives ready and responses)
interface calc2_engine_if #(
    parameter int unsigned NUM_PORTS = 4,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned TAG_W     = 2
);
    logic [4*NUM_PORTS-1:0]      req_cmd_in;
    logic [TAG_W*NUM_PORTS-1:0]  req_tag_in;
    logic [DATA_W*NUM_PORTS-1:0] req_data_in;
    logic [NUM_PORTS-1:0]        req_ready;
    logic [2*NUM_PORTS-1:0]      out_resp;
    logic [TAG_W*NUM_PORTS-1:0]  out_tag;
    logic [DATA_W*NUM_PORTS-1:0] out_data;

    modport master (
        output req_cmd_in, req_tag_in, req_data_in,
        input  req_ready, out_resp, out_tag, out_data
    );

    modport slave (
        input  req_cmd_in, req_tag_in, req_data_in,
        output req_ready, out_resp, out_tag, out_data
    );
endinterface

// File: rtl/calc2_engine.sv
// Multi-port calculator engine. Each requester port captures {cmd,tag,op1}
// in its command cycle and op2 in the following cycle, then pushes the whole
// command into a per-port queue. A round-robin arbiter pops one queued command
// per cycle into a shared execute register; the registered result, response
// code and echoed tag are presented on the originating port for one cycle.
// Ports:
//   c_clk  : clock, rising edge
//   reset  : asynchronous, active-low clear of all state
//   bus    : calc2_engine_if slave modport (commands in, ready/responses out)
module calc2_engine #(
    parameter int unsigned NUM_PORTS  = 4,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned TAG_W      = 2
) (
    input  logic          c_clk,
    input  logic          reset,
    calc2_engine_if.slave bus
);

    localparam int unsigned PTR_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int unsigned AW    = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = AW + 1;
    localparam int unsigned SH_W  = $clog2(DATA_W);

    localparam logic [3:0] CMD_ADD = 4'd1;
    localparam logic [3:0] CMD_SUB = 4'd2;
    localparam logic [3:0] CMD_SHL = 4'd5;
    localparam logic [3:0] CMD_SHR = 4'd6;

    localparam logic [1:0] RESP_OK  = 2'd1;
    localparam logic [1:0] RESP_OVF = 2'd2;
    localparam logic [1:0] RESP_INV = 2'd3;

    logic [NUM_PORTS-1:0] w_ready;
    logic [NUM_PORTS-1:0] w_pop;
    logic [CNT_W-1:0]     w_count    [NUM_PORTS];
    logic [3:0]           w_head_cmd [NUM_PORTS];
    logic [TAG_W-1:0]     w_head_tag [NUM_PORTS];
    logic [DATA_W-1:0]    w_head_op1 [NUM_PORTS];
    logic [DATA_W-1:0]    w_head_op2 [NUM_PORTS];

    logic                 w_grant_valid;
    logic [PTR_W-1:0]     w_grant_port;
    int unsigned          w_scan_idx;

    logic [PTR_W-1:0]     r_arb_ptr;
    logic                 r_ex_valid;
    logic [PTR_W-1:0]     r_ex_port;
    logic [3:0]           r_ex_cmd;
    logic [TAG_W-1:0]     r_ex_tag;
    logic [DATA_W-1:0]    r_ex_op1;
    logic [DATA_W-1:0]    r_ex_op2;

    logic [DATA_W:0]      w_sum;
    logic [SH_W-1:0]      w_shamt;
    logic [1:0]           w_resp;
    logic [DATA_W-1:0]    w_result;

    logic [2*NUM_PORTS-1:0]      r_out_resp;
    logic [TAG_W*NUM_PORTS-1:0]  r_out_tag;
    logic [DATA_W*NUM_PORTS-1:0] r_out_data;

    // Per-port operand capture and command queue
    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        logic [3:0]        w_cmd;
        logic              w_accept;
        logic              r_op2_cycle;
        logic [3:0]        r_cap_cmd;
        logic [TAG_W-1:0]  r_cap_tag;
        logic [DATA_W-1:0] r_cap_op1;
        logic [AW-1:0]     r_wr_ptr;
        logic [AW-1:0]     r_rd_ptr;
        logic [CNT_W-1:0]  r_count;
        logic [3:0]        r_mem_cmd [FIFO_DEPTH];
        logic [TAG_W-1:0]  r_mem_tag [FIFO_DEPTH];
        logic [DATA_W-1:0] r_mem_op1 [FIFO_DEPTH];
        logic [DATA_W-1:0] r_mem_op2 [FIFO_DEPTH];

        assign w_cmd      = bus.req_cmd_in[4*p +: 4];
        // Start-of-cycle occupancy only: a same-cycle pop never frees a full queue
        assign w_ready[p] = reset & ~r_op2_cycle & (r_count < CNT_W'(FIFO_DEPTH));
        assign w_accept   = w_ready[p] & (w_cmd != 4'd0);
        assign w_pop[p]   = w_grant_valid & (w_grant_port == PTR_W'(p));

        assign w_count[p]    = r_count;
        assign w_head_cmd[p] = r_mem_cmd[r_rd_ptr];
        assign w_head_tag[p] = r_mem_tag[r_rd_ptr];
        assign w_head_op1[p] = r_mem_op1[r_rd_ptr];
        assign w_head_op2[p] = r_mem_op2[r_rd_ptr];

        // Capture state and queue pointers; the push happens in the op2 cycle
        always_ff @(posedge c_clk or negedge reset) begin
            if (!reset) begin
                r_op2_cycle <= 1'b0;
                r_cap_cmd   <= '0;
                r_cap_tag   <= '0;
                r_cap_op1   <= '0;
                r_wr_ptr    <= '0;
                r_rd_ptr    <= '0;
                r_count     <= '0;
            end else begin
                r_op2_cycle <= w_accept;
                if (w_accept) begin
                    r_cap_cmd <= w_cmd;
                    r_cap_tag <= bus.req_tag_in[TAG_W*p +: TAG_W];
                    r_cap_op1 <= bus.req_data_in[DATA_W*p +: DATA_W];
                end
                if (r_op2_cycle) r_wr_ptr <= r_wr_ptr + AW'(1);
                if (w_pop[p])    r_rd_ptr <= r_rd_ptr + AW'(1);
                case ({r_op2_cycle, w_pop[p]})
                    2'b10:   r_count <= r_count + CNT_W'(1);
                    2'b01:   r_count <= r_count - CNT_W'(1);
                    default: r_count <= r_count;
                endcase
            end
        end

        // Queue storage; contents are don't-care while the count says empty
        always_ff @(posedge c_clk) begin
            if (r_op2_cycle) begin
                r_mem_cmd[r_wr_ptr] <= r_cap_cmd;
                r_mem_tag[r_wr_ptr] <= r_cap_tag;
                r_mem_op1[r_wr_ptr] <= r_cap_op1;
                r_mem_op2[r_wr_ptr] <= bus.req_data_in[DATA_W*p +: DATA_W];
            end
        end
    end

    // Round-robin grant: first non-empty queue at or after the pointer
    always_comb begin
        w_grant_valid = 1'b0;
        w_grant_port  = '0;
        w_scan_idx    = 0;
        for (int i = int'(NUM_PORTS) - 1; i >= 0; i--) begin
            w_scan_idx = (32'(r_arb_ptr) + 32'(i)) % NUM_PORTS;
            if (w_count[PTR_W'(w_scan_idx)] != '0) begin
                w_grant_valid = 1'b1;
                w_grant_port  = PTR_W'(w_scan_idx);
            end
        end
    end

    // Arbiter pointer and execute register
    always_ff @(posedge c_clk or negedge reset) begin
        if (!reset) begin
            r_arb_ptr  <= '0;
            r_ex_valid <= 1'b0;
            r_ex_port  <= '0;
            r_ex_cmd   <= '0;
            r_ex_tag   <= '0;
            r_ex_op1   <= '0;
            r_ex_op2   <= '0;
        end else begin
            r_ex_valid <= w_grant_valid;
            if (w_grant_valid) begin
                r_arb_ptr <= (w_grant_port == PTR_W'(NUM_PORTS - 1)) ? '0
                                                                     : w_grant_port + PTR_W'(1);
                r_ex_port <= w_grant_port;
                r_ex_cmd  <= w_head_cmd[w_grant_port];
                r_ex_tag  <= w_head_tag[w_grant_port];
                r_ex_op1  <= w_head_op1[w_grant_port];
                r_ex_op2  <= w_head_op2[w_grant_port];
            end
        end
    end

    // Unsigned arithmetic; overflow/underflow and unknown commands return data 0
    always_comb begin
        w_sum    = {1'b0, r_ex_op1} + {1'b0, r_ex_op2};
        w_shamt  = r_ex_op2[SH_W-1:0];
        w_resp   = RESP_INV;
        w_result = '0;
        case (r_ex_cmd)
            CMD_ADD: begin
                if (w_sum[DATA_W]) begin
                    w_resp = RESP_OVF;
                end else begin
                    w_resp   = RESP_OK;
                    w_result = w_sum[DATA_W-1:0];
                end
            end
            CMD_SUB: begin
                if (r_ex_op2 > r_ex_op1) begin
                    w_resp = RESP_OVF;
                end else begin
                    w_resp   = RESP_OK;
                    w_result = r_ex_op1 - r_ex_op2;
                end
            end
            CMD_SHL: begin
                w_resp   = RESP_OK;
                w_result = r_ex_op1 << w_shamt;
            end
            CMD_SHR: begin
                w_resp   = RESP_OK;
                w_result = r_ex_op1 >> w_shamt;
            end
            default: begin
                w_resp   = RESP_INV;
                w_result = '0;
            end
        endcase
    end

    // Response registers: only the executing command's port is non-zero
    always_ff @(posedge c_clk or negedge reset) begin
        if (!reset) begin
            r_out_resp <= '0;
            r_out_tag  <= '0;
            r_out_data <= '0;
        end else begin
            for (int p = 0; p < int'(NUM_PORTS); p++) begin
                if (r_ex_valid && (r_ex_port == PTR_W'(p))) begin
                    r_out_resp[2*p +: 2]          <= w_resp;
                    r_out_tag[TAG_W*p +: TAG_W]   <= r_ex_tag;
                    r_out_data[DATA_W*p +: DATA_W] <= w_result;
                end else begin
                    r_out_resp[2*p +: 2]          <= 2'd0;
                    r_out_tag[TAG_W*p +: TAG_W]   <= '0;
                    r_out_data[DATA_W*p +: DATA_W] <= '0;
                end
            end
        end
    end

    assign bus.req_ready = w_ready;
    assign bus.out_resp  = r_out_resp;
    assign bus.out_tag   = r_out_tag;
    assign bus.out_data  = r_out_data;

endmodule

// File: tb/tb_calc2_engine.sv
// Self-checking bench for calc2_engine: directed scenarios plus randomized
// traffic, compared every cycle against a queue-based transaction model.
module tb_calc2_engine;

    localparam int unsigned NP = 4;
    localparam int unsigned DW = 32;
    localparam int unsigned FD = 4;
    localparam int unsigned TW = 2;

    typedef struct {
        logic [3:0]    cmd;
        logic [TW-1:0] tag;
        logic [DW-1:0] a;
        logic [DW-1:0] b;
    } ent_t;

    logic clk;
    logic rst_n;

    calc2_engine_if #(.NUM_PORTS(NP), .DATA_W(DW), .TAG_W(TW)) bus ();

    calc2_engine #(
        .NUM_PORTS (NP),
        .DATA_W    (DW),
        .FIFO_DEPTH(FD),
        .TAG_W     (TW)
    ) dut (
        .c_clk(clk),
        .reset(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks;
    int n_errors;

    // Stimulus for the current cycle
    logic [3:0]    d_cmd  [NP];
    logic [TW-1:0] d_tag  [NP];
    logic [DW-1:0] d_data [NP];

    // DUT values sampled at the falling edge
    logic [NP-1:0] obs_ready;
    logic [1:0]    obs_resp [NP];
    logic [TW-1:0] obs_tag  [NP];
    logic [DW-1:0] obs_data [NP];

    // Reference model state
    ent_t          m_q     [NP][$];
    logic          m_cap_v [NP];
    ent_t          m_cap   [NP];
    int            m_ptr;
    logic          m_ex_v;
    int            m_ex_p;
    ent_t          m_ex;
    logic [1:0]    m_resp  [NP];
    logic [TW-1:0] m_otag  [NP];
    logic [DW-1:0] m_odata [NP];
    logic [NP-1:0] m_acc;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic void calc(input ent_t e, output logic [1:0] r, output logic [DW-1:0] d);
        longint unsigned s;
        r = 2'd3;
        d = '0;
        case (e.cmd)
            4'd1: begin
                s = 64'(e.a) + 64'(e.b);
                if (s > 64'h0000_0000_FFFF_FFFF) r = 2'd2;
                else begin r = 2'd1; d = DW'(s); end
            end
            4'd2: begin
                if (e.b > e.a) r = 2'd2;
                else begin r = 2'd1; d = e.a - e.b; end
            end
            4'd5: begin r = 2'd1; d = e.a << (e.b % 32); end
            4'd6: begin r = 2'd1; d = e.a >> (e.b % 32); end
            default: begin r = 2'd3; d = '0; end
        endcase
    endfunction

    task automatic model_clear();
        for (int p = 0; p < int'(NP); p++) begin
            m_q[p].delete();
            m_cap_v[p] = 1'b0;
            m_resp[p]  = 2'd0;
            m_otag[p]  = '0;
            m_odata[p] = '0;
        end
        m_ptr  = 0;
        m_ex_v = 1'b0;
        m_ex_p = 0;
        m_acc  = '0;
    endtask

    // Advance the model across one rising edge, given start-of-cycle readiness
    task automatic model_edge(input logic [NP-1:0] rdy);
        logic [1:0]    r;
        logic [DW-1:0] d;
        ent_t          e;
        int            g;
        for (int p = 0; p < int'(NP); p++) begin
            m_resp[p] = 2'd0; m_otag[p] = '0; m_odata[p] = '0;
        end
        if (m_ex_v) begin
            calc(m_ex, r, d);
            m_resp[m_ex_p]  = r;
            m_otag[m_ex_p]  = m_ex.tag;
            m_odata[m_ex_p] = d;
        end
        m_ex_v = 1'b0;
        for (int i = 0; i < int'(NP); i++) begin
            g = (m_ptr + i) % int'(NP);
            if (!m_ex_v && m_q[g].size() > 0) begin
                m_ex   = m_q[g].pop_front();
                m_ex_v = 1'b1;
                m_ex_p = g;
            end
        end
        if (m_ex_v) m_ptr = (m_ex_p + 1) % int'(NP);
        for (int p = 0; p < int'(NP); p++) begin
            if (m_cap_v[p]) begin
                e = m_cap[p];
                e.b = d_data[p];
                m_q[p].push_back(e);
                m_cap_v[p] = 1'b0;
            end
        end
        for (int p = 0; p < int'(NP); p++) begin
            m_acc[p] = rdy[p] && (d_cmd[p] != 4'd0);
            if (m_acc[p]) begin
                m_cap_v[p] = 1'b1;
                m_cap[p]   = '{cmd: d_cmd[p], tag: d_tag[p], a: d_data[p], b: '0};
            end
        end
    endtask

    // One clock cycle: drive, compare at the falling edge, advance the model
    task automatic step();
        logic [NP-1:0] exp_rdy;
        for (int p = 0; p < int'(NP); p++) begin
            bus.req_cmd_in[4*p +: 4]    = d_cmd[p];
            bus.req_tag_in[TW*p +: TW]  = d_tag[p];
            bus.req_data_in[DW*p +: DW] = d_data[p];
        end
        if (!rst_n) model_clear();
        @(negedge clk);
        for (int p = 0; p < int'(NP); p++)
            exp_rdy[p] = rst_n && !m_cap_v[p] && (m_q[p].size() < int'(FD));
        obs_ready = bus.req_ready;
        check("ready", 64'(obs_ready), 64'(exp_rdy));
        for (int p = 0; p < int'(NP); p++) begin
            obs_resp[p] = bus.out_resp[2*p +: 2];
            obs_tag[p]  = bus.out_tag[TW*p +: TW];
            obs_data[p] = bus.out_data[DW*p +: DW];
            check($sformatf("out_p%0d", p), 64'({obs_resp[p], obs_tag[p], obs_data[p]}),
                  64'({m_resp[p], m_otag[p], m_odata[p]}));
        end
        if (rst_n) model_edge(exp_rdy);
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        for (int p = 0; p < int'(NP); p++) begin
            d_cmd[p]  = 4'd0;
            d_tag[p]  = '0;
            d_data[p] = DW'($urandom);
        end
    endtask

    task automatic idle_steps(input int n);
        for (int i = 0; i < n; i++) begin
            idle();
            step();
        end
    endtask

    task automatic run_one(input int p, input logic [3:0] cmd, input logic [TW-1:0] tag,
                           input logic [DW-1:0] a, input logic [DW-1:0] b);
        idle();
        d_cmd[p] = cmd; d_tag[p] = tag; d_data[p] = a;
        step();
        idle();
        d_data[p] = b;
        step();
    endtask

    task automatic do_reset(input int n);
        rst_n = 1'b0;
        idle_steps(n);
        rst_n = 1'b1;
    endtask

    function automatic logic [DW-1:0] rnd_data();
        case ($urandom_range(0, 4))
            0:       return '0;
            1:       return '1;
            2:       return DW'($urandom_range(0, 40));
            default: return DW'($urandom);
        endcase
    endfunction

    function automatic logic [3:0] rnd_cmd();
        logic [3:0] pick [10];
        pick = '{4'd1, 4'd2, 4'd5, 4'd6, 4'd1, 4'd2, 4'd3, 4'd4, 4'd7, 4'd15};
        return pick[$urandom_range(0, 9)];
    endfunction

    initial begin
        logic [TW-1:0] p1_tag;
        n_checks = 0;
        n_errors = 0;
        rst_n = 1'b1;
        idle();
        model_clear();
        #1 rst_n = 1'b0;
        idle_steps(3);
        rst_n = 1'b1;

        // Test 1: add 5+7 on p0, tag 2; response at N+4 only
        run_one(0, 4'd1, 2'd2, 32'h5, 32'h7);
        idle_steps(2);
        idle(); step();
        check("t1_resp", 64'(obs_resp[0]), 64'd1);
        check("t1_data", 64'(obs_data[0]), 64'h0000_000C);
        check("t1_tag",  64'(obs_tag[0]),  64'd2);
        idle(); step();
        check("t1_clear", 64'(obs_resp[0]), 64'd0);

        // Test 2: overflow, underflow, shift amount masking
        run_one(0, 4'd1, 2'd0, 32'hFFFF_FFFF, 32'h1);
        idle_steps(2);
        idle(); step();
        check("t2_add_ovf_resp", 64'(obs_resp[0]), 64'd2);
        check("t2_add_ovf_data", 64'(obs_data[0]), 64'd0);
        run_one(0, 4'd2, 2'd1, 32'h3, 32'h5);
        run_one(0, 4'd5, 2'd3, 32'h1, 32'h21);
        idle(); step();
        check("t2_sub_unf_resp", 64'(obs_resp[0]), 64'd2);
        check("t2_sub_unf_data", 64'(obs_data[0]), 64'd0);
        idle(); step();
        idle(); step();
        check("t2_shl_resp", 64'(obs_resp[0]), 64'd1);
        check("t2_shl_data", 64'(obs_data[0]), 64'd2);
        idle_steps(4);

        // Test 3: all ports issue together from pointer 0
        do_reset(2);
        idle();
        for (int p = 0; p < int'(NP); p++) begin
            d_cmd[p] = 4'd1; d_tag[p] = TW'(p); d_data[p] = DW'(p + 10);
        end
        step();
        idle();
        for (int p = 0; p < int'(NP); p++) d_data[p] = DW'(p);
        step();
        idle_steps(2);
        for (int k = 0; k < int'(NP); k++) begin
            idle(); step();
            check($sformatf("t3_resp_p%0d", k), 64'(obs_resp[k]), 64'd1);
            check($sformatf("t3_tag_p%0d", k),  64'(obs_tag[k]),  64'(k));
            check($sformatf("t3_data_p%0d", k), 64'(obs_data[k]), 64'(2 * k + 10));
        end
        idle_steps(2);

        // Test 4: all ports hammer the arbiter so p1 fills and drops, then drain
        p1_tag = '0;
        for (int c = 0; c < 40; c++) begin
            for (int p = 0; p < int'(NP); p++) begin
                d_cmd[p]  = 4'd1;
                d_tag[p]  = (p == 1) ? p1_tag : TW'($urandom);
                d_data[p] = rnd_data();
            end
            step();
            if (m_acc[1]) p1_tag = p1_tag + TW'(1);
        end
        idle_steps(30);

        // Test 5: reset in the operand2 cycle of p2 cmd 9
        idle();
        d_cmd[2] = 4'd9; d_tag[2] = 2'd1; d_data[2] = 32'h1234;
        step();
        rst_n = 1'b0;
        idle_steps(2);
        rst_n = 1'b1;
        idle(); step();
        check("t5_ready_after_release", 64'(obs_ready), 64'hF);
        idle_steps(8);

        // Test 6: invalid command 4 on p3
        run_one(3, 4'd4, 2'd1, DW'($urandom), DW'($urandom));
        idle_steps(2);
        idle(); step();
        check("t6_resp", 64'(obs_resp[3]), 64'd3);
        check("t6_data", 64'(obs_data[3]), 64'd0);
        check("t6_tag",  64'(obs_tag[3]),  64'd1);
        idle_steps(3);

        // Randomized traffic with occasional mid-stream resets
        for (int c = 0; c < 2000; c++) begin
            if ($urandom_range(0, 399) == 0) rst_n = 1'b0;
            else rst_n = 1'b1;
            for (int p = 0; p < int'(NP); p++) begin
                d_cmd[p]  = ($urandom_range(0, 99) < 55) ? rnd_cmd() : 4'd0;
                d_tag[p]  = TW'($urandom);
                d_data[p] = rnd_data();
            end
            step();
        end
        rst_n = 1'b1;
        idle_steps(40);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
